if_fetch_unit: RTL and testbench

Instruction-fetch stage of the RV32I pipeline, directly upstream of the IF/ID pipeline register. Owns the program counter, issues requests to instruction memory over a req/ack handshake, and presents PC, PC+4 and the fetched instruction with a valid flag. Honours downstream stalls by holding the fetched word, and handles branch/jump redirects, including redirects that arrive while a memory request is still outstanding.

---
 rtl/if_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, drives the imem req/ack port and presents PC/PC+4/instruction.
// Optional build macro IF_ALIGN_CHECK_EN adds the registered misalign_o flag for unaligned redirect targets.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PCplus4,
    output logic [31:0] IF_Instr,
    output logic        if_valid_o,
`ifdef IF_ALIGN_CHECK_EN
    output logic        misalign_o,
`endif
    output logic        if_bubble_o
);

    // state   | meaning
    // IDLE    | one cycle after reset, nothing requested yet
    // FETCH   | request at pc outstanding, data presented in the ack cycle
    // HOLD    | fetched word parked while downstream stalls, no request
    // DRAIN   | redirected with a request in flight; waiting out its ack
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DRAIN} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_hold_instr;
    logic [31:0] w_hold_nxt;
    logic [31:0] r_pend_pc;
    logic [31:0] w_pend_nxt;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;
    logic        w_req;
    logic        w_valid;
    logic [31:0] w_instr;

    assign w_target = {redirect_pc_i[31:2], 2'b00};
    assign w_pc_inc = r_pc + 32'd4;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_hold_instr <= 32'h0;
            r_pend_pc    <= 32'h0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_hold_instr <= w_hold_nxt;
            r_pend_pc    <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_hold_nxt  = r_hold_instr;
        w_pend_nxt  = r_pend_pc;
        w_req       = 1'b0;
        w_valid     = 1'b0;
        w_instr     = 32'h0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_req   = 1'b1;
                w_valid = imem_ack_i & ~redirect_i;
                w_instr = imem_rdata_i;
                if (redirect_i) begin
                    // An unacked request cannot be withdrawn, so the target waits in pend_pc.
                    if (imem_ack_i) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_pend_nxt  = w_target;
                        w_state_nxt = S_DRAIN;
                    end
                end else if (imem_ack_i) begin
                    if (stall_i) begin
                        w_hold_nxt  = imem_rdata_i;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
            end
            S_HOLD: begin
                w_valid = ~redirect_i;
                w_instr = r_hold_instr;
                if (redirect_i) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_FETCH;
                end else if (!stall_i) begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_FETCH;
                end
            end
            S_DRAIN: begin
                w_req = 1'b1;
                if (redirect_i) begin
                    w_pend_nxt = w_target;
                end
                if (imem_ack_i) begin
                    w_pc_nxt    = redirect_i ? w_target : r_pend_pc;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign imem_req_o  = w_req;
    assign imem_addr_o = w_req ? r_pc : 32'h0;
    assign IF_PC       = r_pc;
    assign IF_PCplus4  = w_pc_inc;
    assign IF_Instr    = w_valid ? w_instr : 32'h0;
    assign if_valid_o  = w_valid;
    assign if_bubble_o = ~w_valid;

`ifdef IF_ALIGN_CHECK_EN
    logic r_misalign;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= redirect_i && (r_state != S_IDLE) && (redirect_pc_i[1:0] != 2'b00);
        end
    end

    assign misalign_o = r_misalign;
`else
    logic w_unused_lsb;
    assign w_unused_lsb = ^redirect_pc_i[1:0];
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios with literal expectations, then randomized
// stall/redirect/wait-state traffic checked every cycle against a behavioural model and a memory image.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        reset_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] IF_PC;
    logic [31:0] IF_PCplus4;
    logic [31:0] IF_Instr;
    logic        if_valid_o;
    logic        if_bubble_o;
`ifdef IF_ALIGN_CHECK_EN
    logic        misalign_o;
`endif

    if_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .IF_PC        (IF_PC),
        .IF_PCplus4   (IF_PCplus4),
        .IF_Instr     (IF_Instr),
        .if_valid_o   (if_valid_o),
`ifdef IF_ALIGN_CHECK_EN
        .misalign_o   (misalign_o),
`endif
        .if_bubble_o  (if_bubble_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // memory model
    int          wait_cfg = 0;
    logic        use_dead = 1'b0;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_left = 0;

    // behavioural model of the fetch stage
    logic        m_started;
    logic [31:0] m_pc;
    logic        m_hold;
    logic [31:0] m_hold_word;
    logic        m_drain;
    logic [31:0] m_pend;
    logic        m_mis;

    // outputs sampled during the last step
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_pc;
    logic [31:0] s_pc4;
    logic [31:0] s_instr;
    logic        s_mis;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started   = 1'b0;
        m_pc        = RST_PC;
        m_hold      = 1'b0;
        m_hold_word = 32'h0;
        m_drain     = 1'b0;
        m_pend      = 32'h0;
        m_mis       = 1'b0;
        mem_busy    = 1'b0;
    endtask

    // Asserted mid-cycle to exercise the asynchronous path; released at posedge+1.
    task automatic do_reset();
        reset_n      = 1'b0;
        stall_i      = 1'b0;
        redirect_i   = 1'b0;
        imem_ack_i   = 1'b0;
        imem_rdata_i = 32'h0;
        model_reset();
        #2;
        chk("rst_req",    {31'b0, imem_req_o}, 32'd0);
        chk("rst_valid",  {31'b0, if_valid_o}, 32'd0);
        chk("rst_bubble", {31'b0, if_bubble_o}, 32'd1);
        chk("rst_pc",     IF_PC, RST_PC);
        chk("rst_pc4",    IF_PCplus4, RST_PC + 32'd4);
        chk("rst_instr",  IF_Instr, 32'h0);
`ifdef IF_ALIGN_CHECK_EN
        chk("rst_mis",    {31'b0, misalign_o}, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // One clock cycle: called at posedge+1, drives inputs, checks at posedge+2, returns at next posedge+1.
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
        logic [31:0] t;
        logic [31:0] rdata;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_req;
        logic        e_valid;
        logic        e_mis;
        logic        ack;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        ack   = 1'b0;
        rdata = $urandom;
        if (mem_busy) chk("req_held", {31'b0, imem_req_o}, 32'd1);
        if (imem_req_o) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_addr = imem_addr_o;
                mem_left = (wait_cfg < 0) ? int'($urandom_range(0, 2)) : wait_cfg;
            end else begin
                chk("req_addr_stable", imem_addr_o, mem_addr);
            end
            if (mem_left == 0) begin
                ack      = 1'b1;
                rdata    = use_dead ? 32'hDEAD_BEEF : memf(mem_addr);
                mem_busy = 1'b0;
            end else begin
                mem_left--;
            end
        end
        imem_ack_i   = ack;
        imem_rdata_i = rdata;
        #1;
        s_req   = imem_req_o;
        s_addr  = imem_addr_o;
        s_valid = if_valid_o;
        s_pc    = IF_PC;
        s_pc4   = IF_PCplus4;
        s_instr = IF_Instr;
`ifdef IF_ALIGN_CHECK_EN
        s_mis   = misalign_o;
`else
        s_mis   = 1'b0;
`endif

        t       = {rpc[31:2], 2'b00};
        e_pc    = m_pc;
        e_req   = 1'b0;
        e_valid = 1'b0;
        e_instr = 32'h0;
        e_mis   = m_mis;
        m_mis   = m_started && rd && (rpc[1:0] != 2'b00);
        if (!m_started) begin
            m_started = 1'b1;
        end else if (m_drain) begin
            e_req = 1'b1;
            if (rd) m_pend = t;
            if (ack) begin
                m_pc    = m_pend;
                m_drain = 1'b0;
            end
        end else if (m_hold) begin
            e_valid = !rd;
            e_instr = m_hold_word;
            if (rd || !st) begin
                m_pc   = rd ? t : m_pc + 32'd4;
                m_hold = 1'b0;
            end
        end else begin
            e_req   = 1'b1;
            e_valid = ack && !rd;
            e_instr = rdata;
            if (rd) begin
                if (ack) begin
                    m_pc = t;
                end else begin
                    m_drain = 1'b1;
                    m_pend  = t;
                end
            end else if (ack) begin
                if (st) begin
                    m_hold      = 1'b1;
                    m_hold_word = rdata;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end

        chk("req",    {31'b0, s_req}, {31'b0, e_req});
        if (e_req) chk("addr", s_addr, e_pc);
        chk("valid",  {31'b0, s_valid}, {31'b0, e_valid});
        chk("bubble", {31'b0, if_bubble_o}, {31'b0, !e_valid});
        chk("pc",     s_pc, e_pc);
        chk("pc4",    s_pc4, e_pc + 32'd4);
        chk("instr",  s_instr, e_valid ? e_instr : 32'h0);
`ifdef IF_ALIGN_CHECK_EN
        chk("misalign", {31'b0, s_mis}, {31'b0, e_mis});
`endif
        if (s_valid) chk("instr_vs_image", s_instr, memf(s_pc));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n       = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_ack_i    = 1'b0;
        imem_rdata_i  = 32'h0;
        @(posedge clk);
        #1;

        // zero-wait streaming from reset
        do_reset();
        step(0, 0, 0);
        chk("idle_req", {31'b0, s_req}, 32'd0);
        step(0, 0, 0);
        chk("s1_pc0", s_pc, 32'h100); chk("s1_pc4_0", s_pc4, 32'h104); chk("s1_v0", {31'b0, s_valid}, 32'd1);
        step(0, 0, 0);
        chk("s1_pc1", s_pc, 32'h104); chk("s1_pc4_1", s_pc4, 32'h108);
        step(0, 0, 0);
        chk("s1_pc2", s_pc, 32'h108); chk("s1_pc4_2", s_pc4, 32'h10C);

        // two wait states
        do_reset();
        wait_cfg = 2;
        step(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            chk("s2_addr", s_addr, 32'h100);
            chk("s2_valid", {31'b0, s_valid}, (i == 2) ? 32'd1 : 32'd0);
        end
        step(0, 0, 0);
        chk("s2_next_addr", s_addr, 32'h104);
        chk("s2_next_valid", {31'b0, s_valid}, 32'd0);
        wait_cfg = 0;

        // stall for three cycles while 0x104 is presented
        do_reset();
        step(0, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            chk("s3_pc", s_pc, 32'h104);
            chk("s3_instr", s_instr, memf(32'h104));
            chk("s3_req", {31'b0, s_req}, (i == 0) ? 32'd1 : 32'd0);
        end
        step(0, 0, 0);
        chk("s3_rel_req", {31'b0, s_req}, 32'd0);
        step(0, 0, 0);
        chk("s3_next_addr", s_addr, 32'h108);

        // redirect with an unacked request in flight
        do_reset();
        step(0, 0, 0);
        step(0, 0, 0);
        wait_cfg = 2;
        use_dead = 1'b1;
        step(0, 1, 32'h200);
        chk("s4_addr", s_addr, 32'h104);
        step(0, 0, 0);
        chk("s4_drain_addr", s_addr, 32'h104);
        step(0, 0, 0);
        chk("s4_dead_valid", {31'b0, s_valid}, 32'd0);
        chk("s4_dead_instr", s_instr, 32'h0);
        wait_cfg = 0;
        use_dead = 1'b0;
        step(0, 0, 0);
        chk("s4_target", s_addr, 32'h200);
        chk("s4_target_valid", {31'b0, s_valid}, 32'd1);

        // redirect out of HOLD, then wrap at the top of the address space
        step(1, 0, 0);
        step(1, 1, 32'h300);
        chk("s5_hold_redir_valid", {31'b0, s_valid}, 32'd0);
        step(0, 0, 0);
        chk("s5_addr", s_addr, 32'h300);
        step(0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0);
        chk("s5_top_pc", s_pc, 32'hFFFF_FFFC);
        chk("s5_top_pc4", s_pc4, 32'h0);
        step(0, 0, 0);
        chk("s5_wrap_addr", s_addr, 32'h0);

`ifdef IF_ALIGN_CHECK_EN
        step(0, 1, 32'h202);
        chk("s6_mis_before", {31'b0, s_mis}, 32'd0);
        step(0, 0, 0);
        chk("s6_mis", {31'b0, s_mis}, 32'd1);
        chk("s6_addr", s_addr, 32'h200);
        step(0, 0, 0);
        chk("s6_mis_after", {31'b0, s_mis}, 32'd0);
`endif

        // randomized traffic with random wait states, stalls and (possibly unaligned) redirects
        wait_cfg = -1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset();
            end
            step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
